// File: rtl/multi_view_renderer.sv
// multi_view_renderer: split-screen top-down renderer. Each viewport shows the
// map scrolled around its own player, the player's car at the viewport centre
// and, optionally, the next player's car as a ghost.
// Pipeline: stage 0 (addresses), stage 1 (ROM data + flags), stage 2 (rgb).
// Optional feature macro: MVR_GHOST_EN enables ghost-car rendering.

module multi_view_renderer #(
  parameter int          NUM_VIEWS       = 2,
  parameter int          SCALE_SHIFT     = 2,
  parameter int          MAP_W           = 320,
  parameter int          MAP_H           = 240,
  parameter int          CAR_SIZE        = 75,
  parameter logic [11:0] TRANSPARENT     = 12'h000,
  parameter logic [11:0] OUT_BOUND_COLOR = 12'h6B4,
  parameter logic [11:0] SEPARATOR_COLOR = 12'hFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic                   valid,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   frame_start,
  input  logic [NUM_VIEWS*10-1:0] pos_x,
  input  logic [NUM_VIEWS*10-1:0] pos_y,
  input  logic [NUM_VIEWS*9-1:0]  deg,
  output logic [16:0]            map_addr,
  input  logic [11:0]            map_rgb,
  output logic [16:0]            car_addr_self,
  output logic [16:0]            car_addr_ghost,
  input  logic [11:0]            car_rgb_self,
  input  logic [11:0]            car_rgb_ghost,
  output logic [11:0]            rgb,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int VW   = 640 / NUM_VIEWS;
  localparam int CX   = VW / 2;
  localparam int CY   = 240;
  localparam int HALF = CAR_SIZE / 2;
  localparam int VI_W = (NUM_VIEWS > 1) ? $clog2(NUM_VIEWS) : 1;

  logic [9:0] snap_x   [NUM_VIEWS];
  logic [9:0] snap_y   [NUM_VIEWS];
  logic [8:0] snap_deg [NUM_VIEWS];
  logic [9:0] cur_x    [NUM_VIEWS];
  logic [9:0] cur_y    [NUM_VIEWS];
  logic [8:0] cur_deg  [NUM_VIEWS];
  logic       armed;

  logic [VI_W-1:0]    vi;
  logic [9:0]         rel_x;
  logic signed [11:0] gx, gy;
  logic               oob_n, sep_n, self_n, ghost_n;
  logic [6:0]         self_lx, self_ly;
  logic [16:0]        self_addr, map_addr_n;

  logic valid0, sep0, self0, ghost0, oob0;
  logic valid1, sep1, self1, ghost1, oob1;
  logic [2:0] hs_d, vs_d;

  // Snapshot of all player states, taken at frame start; armed marks it usable.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      for (int unsigned i = 0; i < NUM_VIEWS; i++) begin
        snap_x[i]   <= '0;
        snap_y[i]   <= '0;
        snap_deg[i] <= '0;
      end
    end else if (frame_start) begin
      armed <= 1'b1;
      for (int unsigned i = 0; i < NUM_VIEWS; i++) begin
        snap_x[i]   <= pos_x[10*i +: 10];
        snap_y[i]   <= pos_y[10*i +: 10];
        snap_deg[i] <= deg[9*i +: 9];
      end
    end
  end

  // The first pixel of a frame coincides with frame_start, so it sees the new
  // values directly instead of the snapshot that is being loaded on that edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_VIEWS; i++) begin
      cur_x[i]   = frame_start ? pos_x[10*i +: 10] : snap_x[i];
      cur_y[i]   = frame_start ? pos_y[10*i +: 10] : snap_y[i];
      cur_deg[i] = frame_start ? deg[9*i +: 9]     : snap_deg[i];
    end
  end

  // Viewport index, viewport-relative x and separator columns.
  always_comb begin
    vi    = '0;
    sep_n = 1'b0;
    for (int unsigned k = 1; k < NUM_VIEWS; k++) begin
      if (h_cnt >= 10'(k * VW)) vi = VI_W'(k);
      if (h_cnt == 10'(k * VW - 1) || h_cnt == 10'(k * VW)) sep_n = 1'b1;
    end
    rel_x = h_cnt - 10'(int'(vi) * VW);
  end

  // World coordinates under the pixel and map address.
  always_comb begin
    gx = $signed({2'b00, rel_x >> SCALE_SHIFT}) + $signed({2'b00, cur_x[vi]})
       - $signed(12'(CX >> SCALE_SHIFT));
    gy = $signed({2'b00, v_cnt >> SCALE_SHIFT}) + $signed({2'b00, cur_y[vi]})
       - $signed(12'(CY >> SCALE_SHIFT));
    oob_n = (gx < 0) || (gy < 0) || (gx >= $signed(12'(MAP_W))) || (gy >= $signed(12'(MAP_H)));
    map_addr_n = oob_n ? '0 : 17'(gy) * 17'(MAP_W) + 17'(gx);
  end

  // Own car box, fixed at the viewport centre.
  always_comb begin
    self_n = (rel_x >= 10'(CX - HALF)) && (rel_x <= 10'(CX + HALF)) &&
             (v_cnt >= 10'(CY - HALF)) && (v_cnt <= 10'(CY + HALF));
    self_lx = 7'(rel_x - 10'(CX - HALF));
    self_ly = 7'(v_cnt - 10'(CY - HALF));
  end

  car_addr #(.CAR_SIZE(CAR_SIZE)) u_car_self (
    .deg  (cur_deg[vi]),
    .lx   (self_lx),
    .ly   (self_ly),
    .addr (self_addr)
  );

`ifdef MVR_GHOST_EN
  localparam logic signed [12:0] HALF_S = 13'(HALF);

  logic [VI_W-1:0]    g;
  logic signed [10:0] dx, dy;
  logic signed [12:0] gcx, gcy, rel_s, v_s;
  logic [6:0]         ghost_lx, ghost_ly;
  logic [16:0]        ghost_addr;

  // Ghost car: next player's position relative to this view, scaled to screen.
  always_comb begin
    if (NUM_VIEWS == 1) g = vi;
    else                g = VI_W'((int'(vi) + 1) % NUM_VIEWS);
    dx    = $signed({1'b0, cur_x[g]}) - $signed({1'b0, cur_x[vi]});
    dy    = $signed({1'b0, cur_y[g]}) - $signed({1'b0, cur_y[vi]});
    gcx   = $signed(13'(CX)) + (13'(dx) <<< SCALE_SHIFT);
    gcy   = $signed(13'(CY)) + (13'(dy) <<< SCALE_SHIFT);
    rel_s = $signed({3'b000, rel_x});
    v_s   = $signed({3'b000, v_cnt});
    ghost_n = (NUM_VIEWS > 1) &&
              (rel_s >= gcx - HALF_S) && (rel_s <= gcx + HALF_S) &&
              (v_s   >= gcy - HALF_S) && (v_s   <= gcy + HALF_S);
    ghost_lx = 7'(rel_s - (gcx - HALF_S));
    ghost_ly = 7'(v_s - (gcy - HALF_S));
  end

  car_addr #(.CAR_SIZE(CAR_SIZE)) u_car_ghost (
    .deg  (cur_deg[g]),
    .lx   (ghost_lx),
    .ly   (ghost_ly),
    .addr (ghost_addr)
  );

  // Ghost sprite address register (stage 0).
  always_ff @(posedge clk) begin
    if (rst) car_addr_ghost <= '0;
    else     car_addr_ghost <= ghost_n ? ghost_addr : '0;
  end
`else
  assign ghost_n        = 1'b0;
  assign car_addr_ghost = '0;
`endif

  // Stage 0: ROM addresses and per-pixel flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0        <= 1'b0;
      sep0          <= 1'b0;
      self0         <= 1'b0;
      ghost0        <= 1'b0;
      oob0          <= 1'b0;
      map_addr      <= '0;
      car_addr_self <= '0;
    end else begin
      valid0        <= valid && (armed || frame_start);
      sep0          <= sep_n;
      self0         <= self_n;
      ghost0        <= ghost_n;
      oob0          <= oob_n;
      map_addr      <= map_addr_n;
      car_addr_self <= self_n ? self_addr : '0;
    end
  end

  // Stage 1: flags delayed to line up with ROM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1 <= 1'b0;
      sep1   <= 1'b0;
      self1  <= 1'b0;
      ghost1 <= 1'b0;
      oob1   <= 1'b0;
    end else begin
      valid1 <= valid0;
      sep1   <= sep0;
      self1  <= self0;
      ghost1 <= ghost0;
      oob1   <= oob0;
    end
  end

  // Stage 2: layer priority mux into the output colour.
  always_ff @(posedge clk) begin
    if (rst)                                          rgb <= '0;
    else if (!valid1)                                 rgb <= '0;
    else if (sep1)                                    rgb <= SEPARATOR_COLOR;
    else if (self1 && car_rgb_self != TRANSPARENT)    rgb <= car_rgb_self;
    else if (ghost1 && car_rgb_ghost != TRANSPARENT)  rgb <= car_rgb_ghost;
    else if (oob1)                                    rgb <= OUT_BOUND_COLOR;
    else                                              rgb <= map_rgb;
  end

  // Sync delay line matching the three pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      hs_d <= {hs_d[1:0], hsync_in};
      vs_d <= {vs_d[1:0], vsync_in};
    end
  end

  assign hsync_out = hs_d[2];
  assign vsync_out = vs_d[2];

endmodule

// car_addr: sprite ROM address for a box-local offset. The ROM holds eight
// CAR_SIZE x CAR_SIZE frames, one per 45-degree heading sector.
module car_addr #(
  parameter int CAR_SIZE = 75
) (
  input  logic [8:0]  deg,
  input  logic [6:0]  lx,
  input  logic [6:0]  ly,
  output logic [16:0] addr
);

  localparam int FRAME_PIX = CAR_SIZE * CAR_SIZE;

  logic [3:0] frame;

  // Heading sector selects the frame, offsets index inside it.
  always_comb begin
    frame = 4'(deg / 9'd45);
    addr  = 17'(frame) * 17'(FRAME_PIX) + 17'(ly) * 17'(CAR_SIZE) + 17'(lx);
  end

endmodule

// File: tb/tb_multi_view_renderer.sv
// tb_multi_view_renderer: directed vectors with hand-computed expectations.
// Map ROM model: colour = addr[11:0] ^ 12'h5A5; sprite ROM model: 0 at address
// 0, otherwise {4'hC, addr[7:0]}. Both respond one clock after the address.

module tb_multi_view_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, hsync_in, vsync_in, frame_start;
  logic [19:0] pos_x, pos_y;
  logic [17:0] deg;
  logic [16:0] map_addr, car_addr_self, car_addr_ghost;
  logic [11:0] map_rgb, car_rgb_self, car_rgb_ghost, rgb;
  logic        hsync_out, vsync_out;

  int n_cmp = 0;
  int n_err = 0;

  multi_view_renderer #(.NUM_VIEWS(2), .SCALE_SHIFT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .h_cnt          (h_cnt),
    .v_cnt          (v_cnt),
    .valid          (valid),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .frame_start    (frame_start),
    .pos_x          (pos_x),
    .pos_y          (pos_y),
    .deg            (deg),
    .map_addr       (map_addr),
    .map_rgb        (map_rgb),
    .car_addr_self  (car_addr_self),
    .car_addr_ghost (car_addr_ghost),
    .car_rgb_self   (car_rgb_self),
    .car_rgb_ghost  (car_rgb_ghost),
    .rgb            (rgb),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out)
  );

  always #20 clk = ~clk;

  function automatic logic [11:0] map_rom(input logic [16:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  function automatic logic [11:0] car_rom(input logic [16:0] a);
    return (a == 17'd0) ? 12'h000 : {4'hC, a[7:0]};
  endfunction

  always @(posedge clk) begin
    map_rgb       <= map_rom(map_addr);
    car_rgb_self  <= car_rom(car_addr_self);
    car_rgb_ghost <= car_rom(car_addr_ghost);
  end

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    h_cnt = h;
    v_cnt = v;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; frame_start = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    pix(10'd0, 10'd0);
    pos_x = {10'd25, 10'd15};
    pos_y = {10'd125, 10'd125};
    deg   = '0;
    repeat (3) tick();
    check("rst_rgb", 17'(rgb), 17'h0);
    check("rst_hsync", 17'(hsync_out), 17'd1);
    check("rst_vsync", 17'(vsync_out), 17'd1);
    check("rst_map_addr", map_addr, 17'd0);
    check("rst_self_addr", car_addr_self, 17'd0);

    // Out of reset but no frame_start yet: black.
    rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; valid = 1'b1;
    pix(10'd160, 10'd240);
    repeat (4) tick();
    check("pre_frame_black", 17'(rgb), 17'h0);

    // Self car at the centre of the left view.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("self_addr_centre", car_addr_self, 17'd2812);
    check("map_addr_centre", map_addr, 17'd40015);
    tick();
    check("rgb_not_yet", 17'(rgb), 17'h0);
    tick();
    check("rgb_self_centre", 17'(rgb), 17'hCFC);

    // Self box edges on row 240.
    pix(10'd123, 10'd240); tick(); check("self_left_edge", car_addr_self, 17'd2775);
    pix(10'd122, 10'd240); tick(); check("self_left_out", car_addr_self, 17'd0);
    pix(10'd197, 10'd240); tick(); check("self_right_edge", car_addr_self, 17'd2849);
    pix(10'd198, 10'd240); tick(); check("self_right_out", car_addr_self, 17'd0);

    // P1 at x=10: left edge of view maps to gx=-30.
    pos_x = {10'd25, 10'd10};
    frame_start = 1'b1;
    pix(10'd0, 10'd240);
    tick();
    frame_start = 1'b0;
    check("oob_addr", map_addr, 17'd0);
    tick(); tick();
    check("oob_rgb", 17'(rgb), 17'h6B4);

    // Plain map pixel: gx=20, gy=90.
    pix(10'd200, 10'd100);
    tick();
    check("map_addr", map_addr, 17'd28820);
    tick(); tick();
    check("map_rgb", 17'(rgb), 17'h531);

    // Mid-frame position change is not visible until the next frame.
    pos_x = {10'd25, 10'd14};
    repeat (4) tick();
    check("hold_addr", map_addr, 17'd28820);
    check("hold_rgb", 17'(rgb), 17'h531);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("new_frame_addr", map_addr, 17'd28824);
    tick(); tick();
    check("new_frame_rgb", 17'(rgb), 17'h53D);

    // Separator columns and their neighbours.
    pix(10'd319, 10'd240); repeat (3) tick(); check("sep_319", 17'(rgb), 17'hFFF);
    pix(10'd320, 10'd240); repeat (3) tick(); check("sep_320", 17'(rgb), 17'hFFF);
    pix(10'd318, 10'd240); repeat (3) tick(); check("pre_sep_map", 17'(rgb), 17'h9D0);
    pix(10'd321, 10'd240); repeat (3) tick(); check("post_sep_oob", 17'(rgb), 17'h6B4);
    valid = 1'b0;
    pix(10'd319, 10'd240); repeat (3) tick(); check("invalid_black", 17'(rgb), 17'h0);
    valid = 1'b1;

    // Sync delay: falling edge emerges after exactly three clocks.
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick(); check("hsync_d1", 17'(hsync_out), 17'd1);
    tick(); check("hsync_d2", 17'(hsync_out), 17'd1);
    tick(); check("hsync_d3", 17'(hsync_out), 17'd0);
    check("vsync_d3", 17'(vsync_out), 17'd0);

    // Ghost car: P1=(15,125), P2=(25,125).
    pos_x = {10'd25, 10'd15};
    frame_start = 1'b1;
    pix(10'd200, 10'd240);
    tick();
    frame_start = 1'b0;
    check("ghost_left_self", car_addr_self, 17'd0);
`ifdef MVR_GHOST_EN
    check("ghost_left_addr", car_addr_ghost, 17'd2812);
    tick(); tick();
    check("ghost_left_rgb", 17'(rgb), 17'hCFC);
`else
    check("ghost_left_addr", car_addr_ghost, 17'd0);
    tick(); tick();
    check("ghost_left_rgb", 17'(rgb), 17'h9FC);
`endif
    pix(10'd440, 10'd240);
    tick();
`ifdef MVR_GHOST_EN
    check("ghost_right_addr", car_addr_ghost, 17'd2812);
    tick(); tick();
    check("ghost_right_rgb", 17'(rgb), 17'hCFC);
`else
    check("ghost_right_addr", car_addr_ghost, 17'd0);
    tick(); tick();
    check("ghost_right_rgb", 17'(rgb), 17'h9EA);
`endif

    // Heading selects the sprite frame: 90 degrees -> frame 2.
    deg = {9'd0, 9'd90};
    frame_start = 1'b1;
    pix(10'd160, 10'd240);
    tick();
    frame_start = 1'b0;
    check("deg90_addr", car_addr_self, 17'd14062);
    tick(); tick();
    check("deg90_rgb", 17'(rgb), 17'hCEE);

    // Right map boundary: gx=319 inside, gx=320 outside.
    pos_x = {10'd281, 10'd15};
    frame_start = 1'b1;
    pix(10'd632, 10'd240);
    tick();
    frame_start = 1'b0;
    check("map_last_col", map_addr, 17'd40319);
    pix(10'd636, 10'd240);
    tick();
    check("map_past_col", map_addr, 17'd0);

    // One-clock reset mid-line.
    pix(10'd160, 10'd240);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rgb", 17'(rgb), 17'h0);
    check("midrst_hsync", 17'(hsync_out), 17'd1);
    check("midrst_vsync", 17'(vsync_out), 17'd1);
    check("midrst_map_addr", map_addr, 17'd0);
    repeat (4) tick();
    check("midrst_black", 17'(rgb), 17'h0);
    check("midrst_hsync_live", 17'(hsync_out), 17'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(); tick();
    check("midrst_recover", 17'(rgb), 17'hCEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_view_renderer.md
MULTI_VIEW_RENDERER -- requirements
Module: multi_view_renderer

Interface
REQ-001 Parameter NUM_VIEWS, default 2, number of side-by-side viewports; legal values 1, 2, 4; viewport width VW = 640/NUM_VIEWS.
REQ-002 Parameter SCALE_SHIFT, default 2, map magnification as a shift (world pixel = 2^SCALE_SHIFT screen pixels).
REQ-003 Parameters MAP_W 320, MAP_H 240, CAR_SIZE 75 (square sprite), TRANSPARENT 12'h000, OUT_BOUND_COLOR 12'h6B4, SEPARATOR_COLOR 12'hFFF.
REQ-004 clk  in  1  25 MHz pixel clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 h_cnt, v_cnt  in  10 each  scan position from the VGA controller; valid in 1 active-video flag; hsync_in, vsync_in in 1 each.
REQ-007 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-008 pos_x, pos_y  in  NUM_VIEWS*10  packed world coordinates per player, player i in bits [10i+9:10i]; deg in NUM_VIEWS*9, packed heading per player.
REQ-009 map_addr  out  17  map ROM address; map_rgb in 12, decoded colour with 1-cycle read latency.
REQ-010 car_addr_self, car_addr_ghost  out  17 each  sprite ROM addresses (dual port); car_rgb_self, car_rgb_ghost in 12 each, 1-cycle latency.
REQ-011 rgb  out  12  final pixel colour; hsync_out, vsync_out out 1 each, delayed to align with rgb.

Function
REQ-012 On frame_start, all pos_x/pos_y/deg fields are latched into a snapshot register; rendering uses only the snapshot, so mid-frame input changes become visible the next frame.
REQ-013 View index vi = h_cnt/VW; rel_x = h_cnt - vi*VW; viewport centre = (VW/2, 240).
REQ-014 Stage 0 (registered): compute vi, rel_x, map coordinates gx = (rel_x>>SCALE_SHIFT) + snap_x[vi] - ((VW/2)>>SCALE_SHIFT), gy likewise with 240; both in 12-bit signed.
REQ-015 Out-of-map when gx<0, gy<0, gx>=MAP_W or gy>=MAP_H; then map_addr = 0, else map_addr = gy*MAP_W + gx.
REQ-016 Self box: rel_x within centre_x ± CAR_SIZE/2 and v_cnt within 240 ± CAR_SIZE/2; car_addr_self comes from the car_addr submodule with snap_deg[vi] and box-local offsets, else 0.
REQ-017 Ghost player g = (vi+1) mod NUM_VIEWS; screen offset = sign-extended (snap_x[g]-snap_x[vi]) <<< SCALE_SHIFT in 13-bit signed (same for y), added to the centre; box test and car_addr_ghost use signed compares; 0 outside the box.
REQ-018 Stage 1: ROM data returns; flags (valid, separator, box hits, out-of-map) are carried one cycle to align with the data.
REQ-019 Stage 2 registers rgb with this priority: !valid -> 0; separator (h_cnt == k*VW-1 or k*VW, k>=1) -> SEPARATOR_COLOR; self hit and car_rgb_self != TRANSPARENT -> self; ghost hit and != TRANSPARENT -> ghost; out-of-map -> OUT_BOUND_COLOR; else map_rgb.
REQ-020 Total latency is 3 clk from h_cnt/v_cnt to rgb; hsync_out/vsync_out are the inputs delayed 3 clk.
REQ-021 NUM_VIEWS=1: no separator, ghost disabled (g == vi).

Reset
REQ-022 While rst, rgb=0, hsync_out=vsync_out=1, snapshot cleared to 0, and all pipeline flags are cleared; map and car addresses are 0.
REQ-023 Reset mid-frame: output is black until the next frame_start after rst deasserts; there are no partial snapshots.

Configuration
REQ-024 With macro MVR_GHOST_EN defined, ghost rendering follows REQ-017/019; without it, car_addr_ghost is held at 0, the ghost hit is forced to 0, and the ghost port logic is removed.

Verification
REQ-025 NUM_VIEWS=2, P1=(15,125) deg 0, frame_start, pixel (160,240) -> car_addr_self = sprite centre address, rgb = car colour 3 clk later.
REQ-026 P1=(10,125), pixel (0,240) -> gx = -30, out-of-map -> map_addr 0, rgb 12'h6B4.
REQ-027 P1=(15,125), P2=(25,125), MVR_GHOST_EN -> ghost box in the left view centred at x=200 (160+10*4); in the right view centred at x=120 relative (negative diff correct).
REQ-028 Change pos_x mid-frame -> rgb unchanged until after the next frame_start.
REQ-029 h_cnt=319 and 320 with valid -> rgb 12'hFFF; valid=0 -> rgb 0; hsync_in edge appears on hsync_out exactly 3 clk later.
REQ-030 Assert rst for 1 clk mid-line -> the next cycle gives rgb=0 and hsync_out=vsync_out=1; black persists until frame_start.
